// File: rtl/hs_ifr_word_bus_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hs_ifr_word_bus_arb                                        |
// | Description : Round-robin arbiter sharing one 32-bit memory port between |
// |               NUM_REQ byte/halfword/word requesters. Performs byte-lane  |
// |               alignment (byte enables, write-data replication, read-data |
// |               extraction with sign/zero extension) and flags misaligned  |
// |               or reserved-size accesses with an error response.          |
// |               One transaction outstanding at a time.                     |
// | Ports       : clk_i/rst_ni       clock, async active-low reset           |
// |               req_*              per-requester request channel           |
// |               rsp_*              one-hot response strobe, data, error    |
// |               mem_*              shared downstream memory port           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hs_ifr_word_bus_arb #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [2*NUM_REQ-1:0]      req_size_i,
   input  logic [NUM_REQ-1:0]        req_signed_i,
   input  logic [32*NUM_REQ-1:0]     req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      mem_valid_o,
   input  logic                      mem_ready_i,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic                      mem_we_o,
   output logic [3:0]                mem_be_o,
   output logic [31:0]               mem_wdata_o,
   input  logic                      mem_rvalid_i,
   input  logic [31:0]               mem_rdata_i
);

   localparam int         c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [1:0] c_SZ_BYTE = 2'd0;
   localparam logic [1:0] c_SZ_HALF = 2'd1;
   localparam logic [1:0] c_SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [c_IDX_W-1:0]   r_ptr;
   logic [c_IDX_W-1:0]   r_gnt;
   logic [1:0]           r_addr_lo;
   logic [1:0]           r_size;
   logic                 r_signed;
   logic                 r_we;

   logic                 r_mem_valid;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic                 r_mem_we;
   logic [3:0]           r_mem_be;
   logic [31:0]          r_mem_wdata;

   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic [31:0]          r_rsp_rdata;
   logic                 r_rsp_err;

   logic                 w_any;
   logic [c_IDX_W-1:0]   w_gnt;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [1:0]           w_sel_size;
   logic [31:0]          w_sel_wdata;
   logic                 w_bad;
   logic [3:0]           w_be;
   logic [31:0]          w_lane_wdata;
   logic [7:0]           w_rd_byte;
   logic [15:0]          w_rd_half;
   logic [31:0]          w_rd_ext;
   logic [c_IDX_W-1:0]   w_ptr_nxt;

   // Round-robin search. Scanning from the far end backwards lets the
   // nearest valid requester at/after the pointer win the last assignment.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[c_IDX_W'((int'(r_ptr) + i) % NUM_REQ)]) begin
            w_any = 1'b1;
            w_gnt = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
         end
      end
   end

   assign w_sel_addr  = req_addr_i[int'(w_gnt)*ADDR_W +: ADDR_W];
   assign w_sel_size  = req_size_i[int'(w_gnt)*2 +: 2];
   assign w_sel_wdata = req_wdata_i[int'(w_gnt)*32 +: 32];

   // Reserved size is reported the same way as a misaligned access.
   assign w_bad = (w_sel_size == 2'd3)
                | ((w_sel_size == c_SZ_HALF) & w_sel_addr[0])
                | ((w_sel_size == c_SZ_WORD) & (w_sel_addr[1:0] != 2'b00));

   always_comb begin
      w_be         = 4'hF;
      w_lane_wdata = w_sel_wdata;
      case (w_sel_size)
         c_SZ_BYTE: begin
            w_be         = 4'b0001 << w_sel_addr[1:0];
            w_lane_wdata = {4{w_sel_wdata[7:0]}};
         end
         c_SZ_HALF: begin
            w_be         = 4'b0011 << {w_sel_addr[1], 1'b0};
            w_lane_wdata = {2{w_sel_wdata[15:0]}};
         end
         default: begin
            w_be         = 4'hF;
            w_lane_wdata = w_sel_wdata;
         end
      endcase
   end

   // Read-data lane extraction uses the low address bits captured at grant.
   always_comb begin
      case (r_addr_lo)
         2'd0:    w_rd_byte = mem_rdata_i[7:0];
         2'd1:    w_rd_byte = mem_rdata_i[15:8];
         2'd2:    w_rd_byte = mem_rdata_i[23:16];
         default: w_rd_byte = mem_rdata_i[31:24];
      endcase
      w_rd_half = r_addr_lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (r_size)
         c_SZ_BYTE: w_rd_ext = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
         c_SZ_HALF: w_rd_ext = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
         default:   w_rd_ext = mem_rdata_i;
      endcase
   end

   assign w_ptr_nxt = c_IDX_W'((int'(r_gnt) + 1) % NUM_REQ);

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and the combinational accept strobe. The accept is gated by
   // reset so every output reads zero while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      req_ready_o = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any && rst_ni) begin
               req_ready_o[w_gnt] = 1'b1;
               w_state_nxt        = w_bad ? ST_ERR : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_ready_i) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ERR: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath: captured request, registered memory port and response.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_addr_lo   <= '0;
         r_size      <= '0;
         r_signed    <= 1'b0;
         r_we        <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         // Responses are single-cycle strobes.
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt     <= w_gnt;
                  r_addr_lo <= w_sel_addr[1:0];
                  r_size    <= w_sel_size;
                  r_signed  <= req_signed_i[w_gnt];
                  r_we      <= req_we_i[w_gnt];
                  if (!w_bad) begin
                     r_mem_valid <= 1'b1;
                     r_mem_addr  <= {w_sel_addr[ADDR_W-1:2], 2'b00};
                     r_mem_we    <= req_we_i[w_gnt];
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_lane_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               if (mem_ready_i) begin
                  r_mem_valid <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_we    <= 1'b0;
                  r_mem_be    <= '0;
                  r_mem_wdata <= '0;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  r_rsp_valid[r_gnt] <= 1'b1;
                  r_rsp_rdata        <= r_we ? 32'd0 : w_rd_ext;
                  r_ptr              <= w_ptr_nxt;
               end
            end
            ST_ERR: begin
               r_rsp_valid[r_gnt] <= 1'b1;
               r_rsp_err          <= 1'b1;
               r_ptr              <= w_ptr_nxt;
            end
            default: begin
               r_ptr <= r_ptr;
            end
         endcase
      end
   end

   assign mem_valid_o = r_mem_valid;
   assign mem_addr_o  = r_mem_addr;
   assign mem_we_o    = r_mem_we;
   assign mem_be_o    = r_mem_be;
   assign mem_wdata_o = r_mem_wdata;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rsp_rdata;
   assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: doc/hs_ifr_word_bus_arb.md
Name: hs_ifr_word_bus_arb

Overview:
Round-robin arbiter that shares one 32-bit memory port between NUM_REQ requesters issuing byte, halfword or word accesses. It performs lane alignment: byte enables, write-data replication, read-data extraction and sign/zero extension. It also detects misaligned accesses. It sits between the core-side load/store agents and the shared SRAM/peripheral port. One transaction is outstanding at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width in bits

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_addr_i  in  NUM_REQ*ADDR_W  byte addresses, requester k at [k*ADDR_W +: ADDR_W]
req_we_i  in  NUM_REQ  1 = write, 0 = read
req_size_i  in  2*NUM_REQ  0 = byte, 1 = halfword, 2 = word, 3 = reserved
req_signed_i  in  NUM_REQ  sign-extend read data
req_wdata_i  in  32*NUM_REQ  write data, right-justified
rsp_valid_o  out  NUM_REQ  one-hot, single-cycle response strobe
rsp_rdata_o  out  32  extended read data (0 for writes and errors)
rsp_err_o  out  1  response is an error
mem_valid_o  out  1  downstream request valid
mem_ready_i  in  1  downstream accept
mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0
mem_we_o  out  1  downstream write
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated write data
mem_rvalid_i  in  1  downstream completion (reads and writes)
mem_rdata_i  in  32  downstream read data

Behaviour:
- Reset (async assert, sync deassert assumed upstream): FSM = IDLE, rr pointer = 0. All outputs are 0, including mem_addr_o, mem_be_o, mem_wdata_o and rsp_rdata_o.
- FSM states: IDLE, ISSUE, WAIT, ERR.
- IDLE:
  - If any req_valid_i is high, grant index g is the first valid requester at or after ptr, searching with wrap modulo NUM_REQ.
  - req_ready_o[g] = 1 combinationally in this cycle only.
  - Register g, addr, we, size, signed, wdata.
  - Next state is ERR if the access is misaligned or size = 3; otherwise ISSUE.
  - With no valid request, stay in IDLE and keep req_ready_o = 0.
- Misaligned means: halfword with addr[0] = 1, or word with addr[1:0] != 0.
- ISSUE:
  - mem_valid_o = 1. mem_addr_o = {addr[ADDR_W-1:2], 2'b00}.
  - mem_be_o: byte = 4'b0001 << addr[1:0]; halfword = 4'b0011 << {addr[1], 1'b0}; word = 4'hF. Reads drive the same enables.
  - mem_wdata_o: byte = {4{wdata[7:0]}}; halfword = {2{wdata[15:0]}}; word = wdata.
  - All mem_* outputs are registered and stay stable until mem_ready_i. On mem_valid_o & mem_ready_i, go to WAIT.
  - mem_rvalid_i is ignored in ISSUE.
- WAIT:
  - mem_valid_o = 0.
  - On mem_rvalid_i, in the next cycle assert registered rsp_valid_o[g] = 1 and rsp_err_o = 0.
  - rsp_rdata_o for reads: byte = mem_rdata_i lane addr[1:0]; halfword = lane addr[1]. Zero-extend, or sign-extend when signed = 1. Word = mem_rdata_i.
  - rsp_rdata_o for writes = 0.
  - Set ptr = (g + 1) mod NUM_REQ and return to IDLE.
- ERR:
  - Next cycle: rsp_valid_o[g] = 1, rsp_err_o = 1, rsp_rdata_o = 0.
  - No downstream access. ptr = (g + 1) mod NUM_REQ; return to IDLE.
- Response outputs are held for exactly one cycle, then return to 0. There is no response backpressure.
- A new grant is possible in the same cycle rsp_valid_o is high, because the FSM is already in IDLE.
- Latency for a granted request with mem_ready_i = 1 and mem_rvalid_i one cycle after accept: grant at cycle 0, mem_valid_o at cycle 1, mem_rvalid_i at cycle 2, rsp_valid_o at cycle 3. Error latency: grant at cycle 0, rsp_valid_o at cycle 2.
- Requesters may drop req_valid_i before they are granted. Inputs are sampled only at grant.
- mem_rvalid_i in IDLE or ERR (stray, or left over after a reset mid-transaction) is ignored.
- Reset asserted mid-transaction abandons the transaction immediately: no response is produced.

Test Plan:
- Single read: requester 1 reads a signed byte at 0x1003, mem_rdata_i = 0x80FF_FF7F → mem_be_o = 4'b1000, mem_addr_o = 0x1000. Result: rsp_valid_o = 4'b0010, rsp_rdata_o = 0xFFFF_FF80, rsp_err_o = 0.
- Halfword write: requester 0 writes a halfword at 0x22, wdata = 0x0000_ABCD → mem_be_o = 4'b1100, mem_wdata_o = 0xABCD_ABCD. The response carries rdata = 0 and err = 0.
- Round-robin fairness: all 4 requesters hold valid continuously and ptr = 0 → grants occur in order 0, 1, 2, 3, 0, with no requester granted twice before the others.
- Misaligned word at 0x0002 from requester 2 → mem_valid_o never asserted. Two cycles after grant: rsp_valid_o = 4'b0100, rsp_err_o = 1. The next grant starts search at requester 3.
- Backpressure: mem_ready_i is held at 0 for 5 cycles → mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o stay stable, and no further req_ready_o is asserted.
- Reset in WAIT followed by a stray mem_rvalid_i → all outputs are 0 and no rsp_valid_o is asserted. The next request is arbitrated starting from requester 0.
